// File: rtl/bound_flasher_pkg.sv
// Shared types and bound constants for the bound flasher lamp sequencer.
package bound_flasher_pkg;

  localparam int LED_W = 16;

  localparam logic [LED_W-1:0] B5   = 16'h003F;
  localparam logic [LED_W-1:0] B10  = 16'h07FF;
  localparam logic [LED_W-1:0] LOW5 = 16'h001F;
  localparam logic [LED_W-1:0] FULL = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    UP5,
    DN0,
    UP10,
    DN5,
    UP15,
    BLINK
  } state_t;

endpackage

// File: rtl/bound_flasher.sv
// Thermometer-code lamp sequencer with flick kickback; led registered, one step per edge.
// Zero-latency response to flick on the sampling edge; no backpressure (free-running).
module bound_flasher
  import bound_flasher_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flick,
  output logic [LED_W-1:0]  led
);

  state_t             state_q, state_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               phase_q, phase_d;
  logic [LED_W-1:0]   shift_in, shift_out;
  logic               kick;

  always_comb begin
    state_d   = state_q;
    led_d     = led_q;
    phase_d   = phase_q;
    shift_in  = {led_q[LED_W-2:0], 1'b1};
    shift_out = {1'b0, led_q[LED_W-1:1]};
    // Kickback only fires at the two lower bounds, never mid-ramp.
    kick      = flick && ((led_q == B5) || (led_q == B10));

    case (state_q)
      IDLE: begin
        if (flick) begin
          led_d   = {{(LED_W-1){1'b0}}, 1'b1};
          state_d = UP5;
        end
      end
      UP5: begin
        if (led_q == B5) begin
          led_d   = shift_out;
          state_d = DN0;
        end else begin
          led_d = shift_in;
        end
      end
      DN0: begin
        if (led_q == '0) begin
          led_d   = {{(LED_W-1){1'b0}}, 1'b1};
          state_d = UP10;
        end else begin
          led_d = shift_out;
        end
      end
      UP10: begin
        if (kick) begin
          led_d   = shift_out;
          state_d = DN0;
        end else if (led_q == B10) begin
          led_d   = shift_out;
          state_d = DN5;
        end else begin
          led_d = shift_in;
        end
      end
      DN5: begin
        if (led_q == LOW5) begin
          led_d   = B5;
          state_d = UP15;
        end else begin
          led_d = shift_out;
        end
      end
      UP15: begin
        if (kick) begin
          led_d   = shift_out;
          state_d = DN5;
        end else if (led_q == FULL) begin
          led_d   = '0;
          phase_d = 1'b0;
          state_d = BLINK;
        end else begin
          led_d = shift_in;
        end
      end
      BLINK: begin
        if (!phase_q) begin
          led_d   = FULL;
          phase_d = 1'b1;
        end else begin
          led_d   = '0;
          phase_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        led_d   = '0;
        phase_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      led_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      phase_q <= phase_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_bound_flasher.sv
// Directed bench for bound_flasher: expected led values queued per step, checked after each edge.
module tb_bound_flasher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flick = 1'b0;
  logic [15:0] led;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  bound_flasher dut (
    .clk   (clk),
    .rst   (rst),
    .flick (flick),
    .led   (led)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] th(input int n);
    logic [31:0] v;
    v = (32'h1 << n) - 32'h1;
    return v[15:0];
  endfunction

  task automatic step(input logic f, input logic r, input logic [15:0] e, input string tag);
    logic [15:0] want;
    logic [15:0] got;
    @(negedge clk);
    flick = f;
    rst   = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = led;
    want = exp_q.pop_front();
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s led=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic up(input int lo, input int hi, input logic f, input string tag);
    for (int n = lo; n <= hi; n++) step(f, 1'b0, th(n), tag);
  endtask

  task automatic down(input int hi, input int lo, input logic f, input string tag);
    for (int n = hi; n >= lo; n--) step(f, 1'b0, th(n), tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog led=%h expected=sequence_complete", led);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset and idle hold
    step(1'b0, 1'b1, 16'h0000, "reset");
    step(1'b0, 1'b1, 16'h0000, "reset");
    repeat (3) step(1'b0, 1'b0, 16'h0000, "idle_hold");

    // normal flow from a one-cycle flick
    step(1'b1, 1'b0, th(1), "norm_start");
    up(2, 6, 1'b0, "norm_up5");
    down(5, 0, 1'b0, "norm_dn0");
    up(1, 11, 1'b0, "norm_up10");
    down(10, 5, 1'b0, "norm_dn5");
    up(6, 16, 1'b0, "norm_up15");
    step(1'b0, 1'b0, 16'h0000, "norm_blink0");
    step(1'b0, 1'b0, 16'hFFFF, "norm_blink1");
    step(1'b0, 1'b0, 16'h0000, "norm_blink2");
    repeat (2) step(1'b0, 1'b0, 16'h0000, "norm_idle");

    // kickbacks in UP10 (at 0x003F and 0x07FF) and UP15 (at 0x07FF and 0x003F)
    step(1'b1, 1'b0, th(1), "kb_start");
    up(2, 6, 1'b0, "kb_up5");
    down(5, 0, 1'b0, "kb_dn0");
    up(1, 6, 1'b0, "kb_up10_a");
    step(1'b1, 1'b0, th(5), "kb_up10_b5");
    down(4, 0, 1'b0, "kb_dn0_b");
    up(1, 11, 1'b0, "kb_up10_c");
    step(1'b1, 1'b0, th(10), "kb_up10_b10");
    down(9, 0, 1'b0, "kb_dn0_c");
    up(1, 11, 1'b0, "kb_up10_d");
    down(10, 5, 1'b0, "kb_dn5");
    step(1'b0, 1'b0, th(6), "kb_up15_entry");
    up(7, 11, 1'b0, "kb_up15_a");
    step(1'b1, 1'b0, th(10), "kb_up15_b10");
    down(9, 5, 1'b0, "kb_dn5_b");
    step(1'b0, 1'b0, th(6), "kb_up15_reentry");
    step(1'b1, 1'b0, th(5), "kb_up15_b5");
    step(1'b0, 1'b0, th(6), "kb_dn5_turn");
    up(7, 16, 1'b0, "kb_up15_c");
    step(1'b0, 1'b0, 16'h0000, "kb_blink0");
    step(1'b0, 1'b0, 16'hFFFF, "kb_blink1");
    step(1'b0, 1'b0, 16'h0000, "kb_blink2");

    // flick ignored where no kickback point applies
    step(1'b1, 1'b0, th(1), "ign_start");
    up(2, 6, 1'b1, "ign_up5");
    down(5, 0, 1'b1, "ign_dn0");
    step(1'b1, 1'b0, th(1), "ign_dn0_turn");
    up(2, 6, 1'b1, "ign_up10_lo");
    step(1'b0, 1'b0, th(7), "ign_up10_b5");
    up(8, 11, 1'b1, "ign_up10_hi");
    step(1'b0, 1'b0, th(10), "ign_up10_b10");
    down(9, 5, 1'b1, "ign_dn5");
    step(1'b1, 1'b0, th(6), "ign_dn5_turn");
    step(1'b0, 1'b0, th(7), "ign_up15_b5");
    up(8, 11, 1'b1, "ign_up15_mid");
    step(1'b0, 1'b0, th(12), "ign_up15_b10");
    up(13, 16, 1'b1, "ign_up15_hi");
    step(1'b1, 1'b0, 16'h0000, "ign_full");
    step(1'b1, 1'b0, 16'hFFFF, "ign_blink1");
    step(1'b1, 1'b0, 16'h0000, "ign_blink2");
    step(1'b1, 1'b0, th(1), "held_restart");
    step(1'b0, 1'b1, 16'h0000, "restart_reset");

    // long flick: loops between UP10 and DN0, never above 0x07FF
    step(1'b1, 1'b0, th(1), "long_start");
    up(2, 6, 1'b1, "long_up5");
    down(5, 0, 1'b1, "long_dn0");
    for (int k = 0; k < 4; k++) begin
      up(1, 6, 1'b1, "long_up10");
      down(5, 0, 1'b1, "long_kick");
    end

    // reset mid-run, then idle rules, then reset with flick
    up(1, 9, 1'b0, "mid_up10");
    step(1'b0, 1'b1, 16'h0000, "mid_reset");
    step(1'b0, 1'b0, 16'h0000, "post_reset_idle");
    step(1'b1, 1'b1, 16'h0000, "rst_flick");
    step(1'b0, 1'b0, 16'h0000, "rst_flick_nostart");
    step(1'b1, 1'b0, th(1), "post_reset_start");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
